// File: rtl/nios_mem_pkg.sv
// rtl/nios_mem_pkg.sv - shared widths and FSM encoding for the on-chip memory reader
// Purpose: common definitions imported by the reader top and its stream FIFO.
// Contents: MEM_ADDR_W / MEM_DATA_W defaults and the IDLE/ISSUE/DRAIN state type.
package nios_mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/nios_mem_stream_fifo.sv
// rtl/nios_mem_stream_fifo.sv - small synchronous FIFO holding {data, sop, eop} stream entries
// Purpose: buffers RAM read data between the read master and the output stream.
// Ports: clk, reset_n (async, active-low), i_flush (drop all entries),
//        i_push/i_data (write), i_pop (read head), o_data (head entry),
//        o_empty, o_count (current occupancy).
module nios_mem_stream_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;

  // The writer never pushes into a full FIFO (it holds read credits), so
  // push is taken unconditionally; pop is ignored when empty.
  assign w_do_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push)   r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop) r_rptr <= r_rptr + PTR_W'(1);
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/nios_system_onchip_memory_reader.sv
// rtl/nios_system_onchip_memory_reader.sv - sequential read master streaming on-chip RAM words
// Purpose: on a (base, length) command, reads consecutive RAM words (1-cycle latency)
//          and presents them as a valid/ready stream framed with sop/eop.
// Ports: clk, reset_n (async, active-low); command start/base_addr/length/abort;
//        status busy/done; RAM master mem_address/mem_chipselect/mem_write/
//        mem_byteenable/mem_clken/mem_readdata; stream st_data/st_valid/st_ready/st_sop/st_eop.
module nios_system_onchip_memory_reader
  import nios_mem_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop
);

  localparam int                CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]    CREDITS = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_remaining;
  logic                r_first;
  logic                r_inflight;
  logic                r_infl_sop;
  logic                r_infl_eop;
  logic                r_done;

  logic [CNT_W-1:0]    w_count;
  logic [CNT_W:0]      w_used;
  logic                w_empty;
  logic                w_strobe;
  logic                w_pop;
  logic [DATA_W+1:0]   w_head;

  // Credit check: a read may only be strobed if its word is guaranteed a FIFO slot,
  // counting the word already in flight from the RAM.
  assign w_used   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_strobe = (r_state == ST_ISSUE) && !abort && (w_used < CREDITS);
  assign w_pop    = !w_empty && st_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_inflight  <= 1'b0;
      r_infl_sop  <= 1'b0;
      r_infl_eop  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_strobe;
      if (w_strobe) begin
        r_infl_sop  <= r_first;
        r_infl_eop  <= (r_remaining == REM_ONE);
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - REM_ONE;
        r_first     <= 1'b0;
      end
      if (abort) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              if (length != '0) begin
                r_state     <= ST_ISSUE;
                r_addr      <= base_addr;
                r_remaining <= length;
                r_first     <= 1'b1;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ST_ISSUE: begin
            if (w_strobe && (r_remaining == REM_ONE)) r_state <= ST_DRAIN;
          end
          ST_DRAIN: begin
            // The EOP word leaving the FIFO ends the command.
            if (w_pop && w_head[0]) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // abort flushes the FIFO and, because flush wins over push, also drops the in-flight word.
  nios_mem_stream_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (abort),
    .i_push  (r_inflight),
    .i_data  ({mem_readdata, r_infl_sop, r_infl_eop}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign busy           = (r_state != ST_IDLE);
  assign done           = r_done;
  assign mem_address    = r_addr;
  assign mem_chipselect = w_strobe;
  assign mem_write      = 1'b0;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;
  assign st_valid       = !w_empty;
  assign st_data        = w_head[DATA_W+1:2];
  assign st_sop         = !w_empty && w_head[1];
  assign st_eop         = !w_empty && w_head[0];

endmodule
